// File: rtl/ex_wb_stage_pkg.sv
// Shared definitions for the EX->WB slot and the forwarding unit: opcodes,
// instruction-code field positions and the register-write predicate.
package ex_wb_stage_pkg;

    localparam int IC_W = 8;

    localparam logic [1:0] OP_ALU = 2'b00;
    localparam logic [1:0] OP_IMM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    // Opcode 11 never writes, so an empty slot showing this code can't forward.
    localparam logic [IC_W-1:0] NOP_IC_DEF = 8'hC0;

    localparam int OPC_HI = 7;
    localparam int OPC_LO = 6;
    localparam int RD_HI  = 5;
    localparam int RD_LO  = 3;
    localparam int RS_HI  = 2;
    localparam int RS_LO  = 0;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_e;

    function automatic logic writes_reg(input logic [1:0] opc);
        return (opc == OP_ALU) || (opc == OP_IMM);
    endfunction

endpackage

// File: rtl/ex_wb_stage.sv
// EX->WB single-entry pipeline slot: drives the register-file write port,
// presents the write-back side of forwarding and counts retired instructions.
module ex_wb_stage
    import ex_wb_stage_pkg::*;
#(
    parameter int              DATA_W = 8,
    parameter int              CNT_W  = 16,
    parameter logic [IC_W-1:0] NOP_IC = NOP_IC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ex_valid,
    input  logic [IC_W-1:0]   ex_ic,
    input  logic [DATA_W-1:0] ex_result,
    output logic              ex_ready,
    input  logic              flush,
    input  logic              wb_ready,
    output logic              rf_we,
    output logic [2:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [IC_W-1:0]   EX_WB_IC,
    output logic [DATA_W-1:0] fwd_data,
    output logic              wb_valid,
    output logic [CNT_W-1:0]  retired
);

    slot_state_e       state_q, state_d;
    logic [IC_W-1:0]   slot_ic_q, slot_ic_d;
    logic [DATA_W-1:0] slot_data_q, slot_data_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic slot_valid;
    logic consume;
    logic load;

    assign slot_valid = (state_q == SLOT_FULL);
    assign consume    = slot_valid & wb_ready;
    // Accepting while the old entry drains keeps the slot streaming at one per cycle.
    assign ex_ready   = !slot_valid | wb_ready;
    assign load       = ex_valid & ex_ready & !flush;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        slot_ic_d   = slot_ic_q;
        slot_data_d = slot_data_q;
        retired_d   = retired_q + CNT_W'(consume & !flush);

        if (flush) begin
            state_d   = SLOT_EMPTY;
            slot_ic_d = NOP_IC;
        end else if (load) begin
            state_d     = SLOT_FULL;
            slot_ic_d   = ex_ic;
            slot_data_d = ex_result;
        end else if (consume) begin
            state_d   = SLOT_EMPTY;
            slot_ic_d = NOP_IC;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= SLOT_EMPTY;
            slot_ic_q   <= NOP_IC;
            slot_data_q <= '0;
            retired_q   <= '0;
        end else begin
            state_q     <= state_d;
            slot_ic_q   <= slot_ic_d;
            slot_data_q <= slot_data_d;
            retired_q   <= retired_d;
        end
    end

    // A flushed entry is squashed: it neither writes nor retires.
    assign rf_we    = consume & !flush & writes_reg(slot_ic_q[OPC_HI:OPC_LO]);
    assign rf_waddr = slot_ic_q[RD_HI:RD_LO];
    assign rf_wdata = slot_data_q;
    assign EX_WB_IC = slot_valid ? slot_ic_q : NOP_IC;
    assign fwd_data = slot_data_q;
    assign wb_valid = slot_valid;
    assign retired  = retired_q;

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed self-checking bench for ex_wb_stage: handshake, stall, flush,
// async reset and retired-counter wrap, with hand-computed expectations.
module tb_ex_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [7:0]  ex_ic;
    logic [7:0]  ex_result;
    logic        ex_ready;
    logic        flush;
    logic        wb_ready;
    logic        rf_we;
    logic [2:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic [7:0]  EX_WB_IC;
    logic [7:0]  fwd_data;
    logic        wb_valid;
    logic [15:0] retired;

    int vectors    = 0;
    int miscompares = 0;

    ex_wb_stage dut (
        .clk      (clk),
        .reset    (reset),
        .ex_valid (ex_valid),
        .ex_ic    (ex_ic),
        .ex_result(ex_result),
        .ex_ready (ex_ready),
        .flush    (flush),
        .wb_ready (wb_ready),
        .rf_we    (rf_we),
        .rf_waddr (rf_waddr),
        .rf_wdata (rf_wdata),
        .EX_WB_IC (EX_WB_IC),
        .fwd_data (fwd_data),
        .wb_valid (wb_valid),
        .retired  (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    logic fwd_hit;

    initial begin
        reset     = 1'b1;
        ex_valid  = 1'b0;
        ex_ic     = 8'h00;
        ex_result = 8'h00;
        flush     = 1'b0;
        wb_ready  = 1'b0;

        // Reset state
        #12;
        check("rst_ic",       32'(EX_WB_IC), 32'h0C0);
        check("rst_wb_valid", 32'(wb_valid), 32'h0);
        check("rst_rf_we",    32'(rf_we),    32'h0);
        check("rst_ex_ready", 32'(ex_ready), 32'h1);
        check("rst_retired",  32'(retired),  32'h0);
        check("rst_fwd_data", 32'(fwd_data), 32'h0);
        check("rst_waddr",    32'(rf_waddr), 32'h0);
        check("rst_wdata",    32'(rf_wdata), 32'h0);
        reset = 1'b0;

        // Idle: an empty slot must not forward to "ADD r1,r0" (rs = r0)
        tick();
        fwd_hit = (EX_WB_IC[7:6] == 2'b00 || EX_WB_IC[7:6] == 2'b01) && (EX_WB_IC[5:3] == 3'd0);
        check("idle_ic",      32'(EX_WB_IC), 32'h0C0);
        check("idle_no_fwd",  32'(fwd_hit),  32'h0);
        check("idle_rf_we",   32'(rf_we),    32'h0);

        // Single op00 write to r3
        ex_valid = 1'b1; ex_ic = 8'h1A; ex_result = 8'h5C; wb_ready = 1'b1;
        settle();
        check("t2_ready_empty", 32'(ex_ready), 32'h1);
        check("t2_we_empty",    32'(rf_we),    32'h0);
        tick();
        ex_valid = 1'b0;
        settle();
        check("t2_ic",      32'(EX_WB_IC), 32'h01A);
        check("t2_fwd",     32'(fwd_data), 32'h05C);
        check("t2_we",      32'(rf_we),    32'h1);
        check("t2_waddr",   32'(rf_waddr), 32'h3);
        check("t2_wdata",   32'(rf_wdata), 32'h05C);
        check("t2_ret_pre", 32'(retired),  32'h0);
        tick();
        check("t2_ret",   32'(retired),  32'h1);
        check("t2_empty", 32'(wb_valid), 32'h0);
        check("t2_nop",   32'(EX_WB_IC), 32'h0C0);

        // Stall: 8'h4A held for 3 cycles with wb_ready low, then drains
        ex_valid = 1'b1; ex_ic = 8'h4A; ex_result = 8'h77; wb_ready = 1'b0;
        tick();
        ex_ic = 8'h21; ex_result = 8'h99;
        for (int i = 0; i < 3; i++) begin
            settle();
            check("t3_stall_ready", 32'(ex_ready), 32'h0);
            check("t3_stall_ic",    32'(EX_WB_IC), 32'h04A);
            check("t3_stall_data",  32'(fwd_data), 32'h077);
            check("t3_stall_we",    32'(rf_we),    32'h0);
            check("t3_stall_ret",   32'(retired),  32'h1);
            tick();
        end
        wb_ready = 1'b1;
        settle();
        check("t3_rel_we",    32'(rf_we),    32'h1);
        check("t3_rel_waddr", 32'(rf_waddr), 32'h1);
        check("t3_rel_wdata", 32'(rf_wdata), 32'h077);
        check("t3_rel_ready", 32'(ex_ready), 32'h1);
        tick();
        ex_valid = 1'b0;
        settle();
        check("t3_new_ic",  32'(EX_WB_IC), 32'h021);
        check("t3_new_fwd", 32'(fwd_data), 32'h099);
        check("t3_ret",     32'(retired),  32'h2);
        check("t3_new_we",  32'(rf_we),    32'h1);
        check("t3_new_wa",  32'(rf_waddr), 32'h4);
        tick();
        check("t3_ret2", 32'(retired), 32'h3);

        // Back-to-back 08, 10, 98
        ex_valid = 1'b1; ex_ic = 8'h08; ex_result = 8'h11;
        tick();
        ex_ic = 8'h10; ex_result = 8'h22;
        settle();
        check("t4_ic0",  32'(EX_WB_IC), 32'h008);
        check("t4_we0",  32'(rf_we),    32'h1);
        check("t4_wa0",  32'(rf_waddr), 32'h1);
        check("t4_wd0",  32'(rf_wdata), 32'h011);
        tick();
        ex_ic = 8'h98; ex_result = 8'h33;
        settle();
        check("t4_ic1",  32'(EX_WB_IC), 32'h010);
        check("t4_we1",  32'(rf_we),    32'h1);
        check("t4_wa1",  32'(rf_waddr), 32'h2);
        check("t4_wd1",  32'(rf_wdata), 32'h022);
        tick();
        ex_valid = 1'b0;
        settle();
        check("t4_ic2",    32'(EX_WB_IC), 32'h098);
        check("t4_we2",    32'(rf_we),    32'h0);
        check("t4_valid2", 32'(wb_valid), 32'h1);
        tick();
        check("t4_ret",   32'(retired),  32'h6);
        check("t4_empty", 32'(wb_valid), 32'h0);

        // Flush while FULL with a new offer and wb_ready high
        ex_valid = 1'b1; ex_ic = 8'h1A; ex_result = 8'h44; wb_ready = 1'b0;
        tick();
        ex_ic = 8'h08; ex_result = 8'h55; wb_ready = 1'b1; flush = 1'b1;
        settle();
        check("t5_full",  32'(wb_valid), 32'h1);
        check("t5_we",    32'(rf_we),    32'h0);
        tick();
        flush = 1'b0; ex_valid = 1'b0;
        settle();
        check("t5_empty", 32'(wb_valid), 32'h0);
        check("t5_ic",    32'(EX_WB_IC), 32'h0C0);
        check("t5_ret",   32'(retired),  32'h6);

        // Async reset mid-stall drops the entry without a write
        ex_valid = 1'b1; ex_ic = 8'h4A; ex_result = 8'h66; wb_ready = 1'b0;
        tick();
        ex_valid = 1'b0;
        settle();
        check("t6_full", 32'(wb_valid), 32'h1);
        reset = 1'b1;
        #1;
        check("t6_rst_valid", 32'(wb_valid), 32'h0);
        check("t6_rst_ic",    32'(EX_WB_IC), 32'h0C0);
        check("t6_rst_ret",   32'(retired),  32'h0);
        wb_ready = 1'b1;
        #1;
        check("t6_rst_we",    32'(rf_we),    32'h0);
        reset = 1'b0;
        tick();
        check("t6_after_we",  32'(rf_we),    32'h0);
        check("t6_after_ret", 32'(retired),  32'h0);

        // Retired counter wrap: stream op11 codes, one retirement per cycle
        ex_valid = 1'b1; ex_ic = 8'hD0; ex_result = 8'h00; wb_ready = 1'b1;
        for (int i = 0; i < 65536; i++) begin
            tick();
        end
        check("t7_ret_max", 32'(retired), 32'h0000FFFF);
        check("t7_we_nop",  32'(rf_we),   32'h0);
        ex_valid = 1'b0;
        tick();
        check("t7_ret_wrap", 32'(retired),  32'h0);
        check("t7_empty",    32'(wb_valid), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ex_wb_stage.md
Name: ex_wb_stage

Overview:
- EX->WB pipeline slot of the 8-bit core; it produces the write-back side of the forwarding protocol.
- Captures the executed instruction code and ALU result, drives the register-file write port, and presents EX_WB_IC / fwd_data to the forwarding unit.
- Single-entry buffer with a ready/valid handshake: upstream via ex_ready, downstream via wb_ready.
- Also keeps a retired-instruction counter.

Parameters:
- DATA_W, 8, width of ALU result and register-file data.
- CNT_W, 16, width of retired-instruction counter.
- NOP_IC, 8'hC0, instruction code presented when the slot is empty (opcode 11 never writes, so it never triggers forwarding).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EX stage offers an instruction this cycle.
- ex_ic  input  8  instruction code: [7:6] opcode, [5:3] rd, [2:0] rs.
- ex_result  input  DATA_W  ALU result for ex_ic.
- ex_ready  output  1  slot can accept this cycle.
- flush  input  1  discard slot contents (branch redirect).
- wb_ready  input  1  register file accepts the write / retire this cycle.
- rf_we  output  1  register-file write enable.
- rf_waddr  output  3  destination register.
- rf_wdata  output  DATA_W  write data.
- EX_WB_IC  output  8  instruction code seen by the forwarding unit.
- fwd_data  output  DATA_W  forwarded operand value.
- wb_valid  output  1  slot holds a valid instruction.
- retired  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (async, immediate): slot_valid=0, slot_ic=NOP_IC, slot_data=0, retired=0.
  - Outputs follow: EX_WB_IC=NOP_IC, wb_valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, fwd_data=0, ex_ready=1.
- State is the slot flag: EMPTY (slot_valid=0) or FULL (slot_valid=1).
- consume = slot_valid & wb_ready.
- ex_ready = !slot_valid | wb_ready. This is combinational, so the slot accepts on the same cycle the old entry is consumed.
- load = ex_valid & ex_ready & !flush.
- Writes-register predicate: opcode 00 or 01.
  - rf_we = slot_valid & wb_ready & (slot_ic[7:6]==00 | slot_ic[7:6]==01).
  - Opcodes 10 and 11 retire without writing.
- rf_waddr = slot_ic[5:3]; rf_wdata = slot_data.
- EX_WB_IC = slot_valid ? slot_ic : NOP_IC. An empty slot must never present opcode 00/rd=0, which would cause a false forward.
- fwd_data = slot_data. It is meaningful only when EX_WB_IC writes.
- Next state:
  - flush: slot_valid<=0, slot_ic<=NOP_IC. flush has priority over load. The flushed entry does not count as retired, even if wb_ready=1, and rf_we is forced 0 that cycle.
  - load: slot_ic<=ex_ic, slot_data<=ex_result, slot_valid<=1. Latency is 1 cycle from EX to WB/forward visibility.
  - consume & !load: slot_valid<=0, slot_ic<=NOP_IC.
  - FULL & !wb_ready: hold all slot contents. ex_ready=0 back-pressures EX with no data loss.
- retired increments by 1 on consume & !flush. It wraps modulo 2^CNT_W (FFFF->0000) with no saturation.
- Simultaneous load and consume: the old entry writes back and the new entry is latched in the same edge. retired still increments exactly once.
- Reset asserted mid-stall: the entry is lost and no write occurs.

Decomposition:
- Shared package holds:
  - opcode constants OP_ALU=2'b00, OP_IMM=2'b01, OP_BR=2'b10, OP_NOP=2'b11;
  - NOP_IC;
  - field slice positions (OPC 7:6, RD 5:3, RS 2:0);
  - a writes_reg(opcode) function, shared with the forwarding unit.
- No sub-module; the counter is inline.

Test Plan:
- Reset, then idle:
  - expect EX_WB_IC=8'hC0, rf_we=0, ex_ready=1, retired=0;
  - confirm that "ADD r1,r0" (8'h08) in ID/EX yields no forward.
- ex_ic=8'h1A (op00, rd=3), ex_result=8'h5C, wb_ready=1 -> next cycle:
  - EX_WB_IC=8'h1A, fwd_data=8'h5C, rf_we=1, rf_waddr=3, rf_wdata=8'h5C;
  - retired=1 on the following edge.
- Load 8'h4A (op01, rd=1) with wb_ready=0 for 3 cycles:
  - ex_ready=0, slot holds 8'h4A and rf_we=0 throughout;
  - wb_ready=1 -> one write to r1, and a new ex_ic is accepted the same cycle.
- Back-to-back 8'h08, 8'h10, 8'h98 with wb_ready=1:
  - writes to r1 and r2;
  - 8'h98 (op10) retires with rf_we=0;
  - retired advances by 3.
- flush asserted while FULL with ex_valid=1 and wb_ready=1:
  - rf_we=0, retired unchanged;
  - next cycle slot empty and EX_WB_IC=8'hC0.
- Preload retired=16'hFFFF via 65535 retirements (or force), then one more retirement -> retired=16'h0000.
